fft_peak_search: RTL and testbench
==================================

FFT_PEAK_SEARCH -- requirements
Module: fft_peak_search

Interface
REQ-001 SHALL have parameter N_BINS, default 512, number of magnitude bins scanned from address 0 (half of the 1024-point spectrum).
REQ-002 SHALL have parameter RD_LAT, default 2, fixed magnitude-RAM read latency in cycles from address to data.
REQ-003 SHALL have parameter DC_SKIP, default 2, number of low bins excluded when PEAK_SKIP_DC_EN is defined.
REQ-004 SHALL have port sys_clk, input, 1, the single clock, same clock as the magnitude RAM read port.
REQ-005 SHALL have port sys_rst_n, input, 1, reset; one clock, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a scan.
REQ-007 SHALL have port rd_addr, output, 10, magnitude RAM read address.
REQ-008 SHALL have port rd_data, input, 12, magnitude RAM read data, valid RD_LAT cycles after rd_addr.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when results update.
REQ-011 SHALL have port peak_bin, output, 10, index of the largest magnitude found.
REQ-012 SHALL have port peak_mag, output, 12, magnitude at peak_bin.

Function
REQ-013 SHALL implement FSM IDLE -> SCAN -> DRAIN -> IDLE.
REQ-014 SHALL leave IDLE for SCAN on start=1.
REQ-015 SHALL ignore start in SCAN and DRAIN.
REQ-016 SHALL in SCAN drive rd_addr = 0,1,...,N_BINS-1, one per cycle, then enter DRAIN.
REQ-017 SHALL in DRAIN wait RD_LAT cycles, then return to IDLE.
REQ-018 SHALL delay an address-valid tag and the address through an RD_LAT-deep shift register aligned with rd_data.
REQ-019 SHALL replace the running maximum only on strictly greater data (unsigned compare), so ties keep the lowest bin.
REQ-020 SHALL seed the running maximum with value 0 and bin 0 at scan start.
REQ-021 SHALL update peak_bin and peak_mag together, in the same cycle done pulses: N_BINS+RD_LAT+1 cycles after start is sampled.
REQ-022 SHALL hold peak_bin and peak_mag between scans.
REQ-023 SHALL hold rd_addr at 0 outside SCAN.
REQ-024 SHALL report bin 0 and magnitude 0 if all scanned data is zero.

Reset
REQ-025 SHALL drive all outputs to 0 and the FSM to IDLE on sys_rst_n=0, asynchronously.
REQ-026 SHALL deassert reset synchronously via one internal ipsxe_fft_sync_arstn instance.
REQ-027 SHALL, on reset mid-scan, abort the scan, produce no done pulse, and leave peak outputs at 0.

Configuration
REQ-028 SHALL, with PEAK_SKIP_DC_EN defined, exclude tags with bin < DC_SKIP from comparison and seed the peak at bin DC_SKIP with magnitude 0.
REQ-029 SHALL, without PEAK_SKIP_DC_EN, compare all bins 0..N_BINS-1; DC_SKIP is then unused.

Structure
REQ-030 SHALL place the FSM state enum, the 10-bit address width and the 12-bit magnitude width constants in shared package fft_dso_pkg.
REQ-031 SHALL be a single module with no sub-modules other than the reset synchronizer.

Verification
REQ-032 SHALL cover: RAM = ramp, mag[i]=i -> peak_bin=511, peak_mag=0x1FF, done exactly 515 cycles after start (RD_LAT=2).
REQ-033 SHALL cover: all zero except bin 100 = 0xABC -> peak_bin=100, peak_mag=0xABC.
REQ-034 SHALL cover: bins 30 and 200 both = 0x800, others 0x010 -> peak_bin=30.
REQ-035 SHALL cover: bin 0 = 0xFFF, bin 50 = 0x100, rest 0 -> peak_bin=50 with PEAK_SKIP_DC_EN, peak_bin=0 without it.
REQ-036 SHALL cover: second start pulse mid-scan -> ignored, exactly one done pulse, rd_addr sequence unbroken.
REQ-037 SHALL cover: sys_rst_n low at rd_addr=200 -> outputs 0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/fft_dso_pkg.sv
// Shared widths and FSM state encoding for the FFT display peak search.
package fft_dso_pkg;
  localparam int ADDR_W = 10;
  localparam int MAG_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/ipsxe_fft_sync_arstn.sv
// Reset synchronizer: asserts asynchronously, releases on the second clock edge.
module ipsxe_fft_sync_arstn (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n
);
  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta  <= 1'b0;
      rst_n <= 1'b0;
    end else begin
      meta  <= 1'b1;
      rst_n <= meta;
    end
  end
endmodule

// File: rtl/fft_peak_search.sv
// Scans N_BINS magnitude-RAM words and reports the first largest bin and its value.
// Optional macro PEAK_SKIP_DC_EN excludes bins below DC_SKIP from the search.
module fft_peak_search
  import fft_dso_pkg::*;
#(
  parameter int N_BINS  = 512,
  parameter int RD_LAT  = 2,
  parameter int DC_SKIP = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [MAG_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [MAG_W-1:0]  peak_mag
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);

  logic              rst_n;
  state_t            state;
  logic              addr_vld;
  logic [7:0]        drain_cnt;
  logic [RD_LAT-1:0] tag_vld;
  logic [ADDR_W-1:0] tag_addr [RD_LAT];
  logic [ADDR_W-1:0] max_bin;
  logic [MAG_W-1:0]  max_mag;
  logic              fin;
  logic              tag_ok;
  logic              tag_last;
  logic              take;

  ipsxe_fft_sync_arstn u_rst_sync (
    .clk    (sys_clk),
    .arst_n (sys_rst_n),
    .rst_n  (rst_n)
  );

`ifdef PEAK_SKIP_DC_EN
  localparam logic [ADDR_W-1:0] SEED_BIN = ADDR_W'(DC_SKIP);
  assign tag_ok = tag_vld[RD_LAT-1] && (tag_addr[RD_LAT-1] >= SEED_BIN);
`else
  localparam logic [ADDR_W-1:0] SEED_BIN = '0;
  localparam int unused_dc_skip = DC_SKIP;
  assign tag_ok = tag_vld[RD_LAT-1];
`endif

  // Tail of the tag pipe lines up with rd_data; strict compare keeps the lowest bin on ties.
  assign tag_last = tag_vld[RD_LAT-1] && (tag_addr[RD_LAT-1] == LAST_ADDR);
  assign take     = tag_ok && (rd_data > max_mag);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_addr[i] <= '0;
    end else begin
      tag_vld[0]  <= addr_vld;
      tag_addr[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      addr_vld  <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fin       <= 1'b0;
      max_bin   <= '0;
      max_mag   <= '0;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      done <= 1'b0;
      fin  <= tag_last;
      if (take) begin
        max_mag <= rd_data;
        max_bin <= tag_addr[RD_LAT-1];
      end
      // Results publish one cycle after the last bin has been folded in.
      if (fin) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        peak_bin <= max_bin;
        peak_mag <= max_mag;
      end
      case (state)
        ST_IDLE: begin
          if (start && !busy) begin
            state    <= ST_SCAN;
            busy     <= 1'b1;
            addr_vld <= 1'b1;
            rd_addr  <= '0;
            max_bin  <= SEED_BIN;
            max_mag  <= '0;
          end
        end
        ST_SCAN: begin
          if (rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            rd_addr   <= '0;
            addr_vld  <= 1'b0;
            drain_cnt <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 8'(RD_LAT - 1)) state <= ST_IDLE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_peak_search.sv
// Self-checking bench for fft_peak_search: RAM model, vector table, scoreboard queue.
module tb_fft_peak_search;
  localparam int N_BINS  = 512;
  localparam int RD_LAT  = 2;
  localparam int DC_SKIP = 2;
  localparam int LAT     = N_BINS + RD_LAT + 1;

  typedef struct {
    int         pat;
    logic       use_model;
    logic [9:0] bin;
    logic [11:0] mag;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic        busy;
  logic        done;
  logic [9:0]  peak_bin;
  logic [11:0] peak_mag;

  logic [11:0] mem [1024];
  logic [11:0] rd_pipe [RD_LAT];
  logic [21:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  fft_peak_search #(.N_BINS(N_BINS), .RD_LAT(RD_LAT), .DC_SKIP(DC_SKIP)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag)
  );

  always #5 sys_clk = ~sys_clk;

  // Magnitude RAM with a fixed RD_LAT-cycle read pipeline.
  always @(posedge sys_clk) begin
    rd_pipe[0] <= mem[rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  always @(negedge sys_clk) if (done) done_cnt++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        0:       mem[i] = 12'(i);
        1:       mem[i] = (i == 100) ? 12'hABC : 12'h000;
        2:       mem[i] = (i == 30 || i == 200) ? 12'h800 : 12'h010;
        3:       mem[i] = (i == 0) ? 12'hFFF : ((i == 50) ? 12'h100 : 12'h000);
        4:       mem[i] = 12'h000;
        default: mem[i] = (i >= N_BINS) ? 12'hFFF : 12'($urandom_range(0, 4000));
      endcase
    end
  endtask

  function automatic logic [21:0] model();
    logic [9:0]  b;
    logic [11:0] m;
    int first;
    first = 0;
`ifdef PEAK_SKIP_DC_EN
    first = DC_SKIP;
`endif
    b = 10'(first);
    m = 12'h000;
    for (int i = first; i < N_BINS; i++) begin
      if (mem[i] > m) begin
        m = mem[i];
        b = 10'(i);
      end
    end
    return {b, m};
  endfunction

  // Starts a scan, optionally re-pulses start at cycle extra_at, and scores the result.
  task automatic run_scan(input string tag, input int extra_at);
    int lat;
    int d0;
    int seq_bad;
    int busy_bad;
    logic [21:0] e;
    lat = -1;
    seq_bad = 0;
    busy_bad = 0;
    d0 = done_cnt;
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    for (int j = 0; j < LAT + 10; j++) begin
      @(negedge sys_clk);
      start = (j == extra_at);
      if (j < N_BINS) begin
        if (rd_addr != 10'(j)) seq_bad++;
      end else if (rd_addr != 10'd0) seq_bad++;
      if (j < LAT) begin
        if (busy != 1'b1) busy_bad++;
      end else if (busy != 1'b0) busy_bad++;
      if (done && lat < 0) begin
        lat = j;
        if (exp_q.size() == 0) begin
          check({tag, " scoreboard_empty"}, 0, 1);
        end else begin
          e = exp_q.pop_front();
          check({tag, " peak_bin"}, int'(peak_bin), int'(e[21:12]));
          check({tag, " peak_mag"}, int'(peak_mag), int'(e[11:0]));
        end
      end
    end
    start = 1'b0;
    if (lat < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, " done_latency"}, lat, LAT);
    check({tag, " done_count"}, done_cnt - d0, 1);
    check({tag, " rd_addr_seq_errs"}, seq_bad, 0);
    check({tag, " busy_errs"}, busy_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [21:0] e;
    int d0;

    for (int i = 0; i < 1024; i++) mem[i] = 12'h000;
    vecs[0] = '{0, 1'b0, 10'd511, 12'h1FF};
    vecs[1] = '{1, 1'b0, 10'd100, 12'hABC};
    vecs[2] = '{2, 1'b0, 10'd30,  12'h800};
`ifdef PEAK_SKIP_DC_EN
    vecs[3] = '{3, 1'b0, 10'd50,  12'h100};
    vecs[4] = '{4, 1'b0, 10'(DC_SKIP), 12'h000};
`else
    vecs[3] = '{3, 1'b0, 10'd0,   12'hFFF};
    vecs[4] = '{4, 1'b0, 10'd0,   12'h000};
`endif
    vecs[5] = '{5, 1'b1, 10'd0,   12'h000};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst rd_addr", int'(rd_addr), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst peak_bin", int'(peak_bin), 0);
    check("rst peak_mag", int'(peak_mag), 0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat);
      e = vecs[v].use_model ? model() : {vecs[v].bin, vecs[v].mag};
      exp_q.push_back(e);
      run_scan($sformatf("vec%0d", v), -1);
    end

    // Second start in the middle of a scan must be ignored.
    fill(2);
    exp_q.push_back({10'd30, 12'h800});
    run_scan("midstart", 250);
    d0 = done_cnt;
    repeat (20) @(negedge sys_clk);
    check("hold peak_bin", int'(peak_bin), 30);
    check("hold peak_mag", int'(peak_mag), 12'h800);
    check("hold no_done", done_cnt - d0, 0);

    // Reset asserted mid-scan at rd_addr = 200.
    fill(1);
    d0 = done_cnt;
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    for (int j = 0; j < N_BINS && rd_addr != 10'd200; j++) @(negedge sys_clk);
    check("abort reached_200", int'(rd_addr), 200);
    sys_rst_n = 1'b0;
    #1;
    check("abort rd_addr", int'(rd_addr), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort peak_bin", int'(peak_bin), 0);
    check("abort peak_mag", int'(peak_mag), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (LAT + 10) @(negedge sys_clk);
    check("abort done_count", done_cnt - d0, 0);
    check("abort peak_bin_after", int'(peak_bin), 0);
    check("abort peak_mag_after", int'(peak_mag), 0);
    check("abort busy_after", int'(busy), 0);

    exp_q.push_back({10'd100, 12'hABC});
    run_scan("after_rst", -1);

    check("scoreboard_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
